// File: rtl/spi_xfer_ctrl.sv
// SPI byte sequencer: TX/RX FIFOs (first-word fall-through) around an IDLE/SETUP/XFER/HOLD chip-select FSM.
// Latency: first byte CS_SETUP clk after CS falls; chained bytes have no CS gap. Backpressure: tx_ready=!TX full, a byte starts only with RX room.
module spi_xfer_ctrl #(
  parameter int DEPTH    = 4,
  parameter int CS_SETUP = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] clkdiv,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       cs_hold,
  output logic       busy,
  output logic       SPI_CS,
  output logic       clkr,
  output logic [7:0] spi_tx_byte,
  output logic       spi_transfer,
  input  logic       spi_tx_busy,
  input  logic [7:0] spi_rx_byte,
  input  logic       spi_rx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (CS_SETUP < 2) ? 1 : $clog2(CS_SETUP + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] setup_cnt;
  logic [7:0]    div_q;
  logic [7:0]    div_cnt;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [AW+1:0] rx_cnt_next;
  logic rx_room_after;
  logic unused_tx_busy;

  assign unused_tx_busy = spi_tx_busy;

  assign tx_full  = (tx_cnt == (AW+1)'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == (AW+1)'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_mem[rx_rp];
  assign rx_pop   = rx_ready && !rx_empty;
  assign rx_push  = (state == XFER) && spi_rx_ready;

  assign busy         = (state != IDLE);
  assign spi_transfer = (state == XFER) && !spi_rx_ready;

  // Room test for chaining counts the byte landing now and any same-cycle reader pop.
  assign rx_cnt_next   = {1'b0, rx_cnt} + (AW+2)'(rx_push) - (AW+2)'(rx_pop);
  assign rx_room_after = (rx_cnt_next < (AW+2)'(DEPTH));

  always_comb begin
    tx_pop = 1'b0;
    case (state)
      SETUP:   tx_pop = (setup_cnt <= SW'(1)) && !tx_empty && !rx_full;
      XFER:    tx_pop = spi_rx_ready && !tx_empty && rx_room_after;
      HOLD:    tx_pop = !tx_empty && !rx_full;
      default: tx_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
    if (rx_push) rx_mem[rx_wp] <= spi_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      setup_cnt   <= '0;
      spi_tx_byte <= '0;
      div_q       <= '0;
      SPI_CS      <= 1'b1;
    end else begin
      if (tx_pop) spi_tx_byte <= tx_mem[tx_rp];
      case (state)
        IDLE: begin
          div_q <= clkdiv;
          if (!tx_empty) begin
            state     <= SETUP;
            setup_cnt <= SW'(CS_SETUP);
            SPI_CS    <= 1'b0;
          end
        end
        SETUP: begin
          if (tx_pop) state <= XFER;
          else if (setup_cnt > SW'(1)) setup_cnt <= setup_cnt - 1'b1;
        end
        XFER: begin
          if (spi_rx_ready && !tx_pop) begin
            state  <= cs_hold ? HOLD : IDLE;
            SPI_CS <= !cs_hold;
          end
        end
        default: begin
          if (tx_pop) state <= XFER;
          else if (!cs_hold) begin
            state  <= IDLE;
            SPI_CS <= 1'b1;
          end
        end
      endcase
    end
  end

  // Divider restarts each byte so every byte begins with clkr low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt <= '0;
      clkr    <= 1'b0;
    end else if (state == XFER && !spi_rx_ready) begin
      if (div_cnt == div_q) begin
        div_cnt <= '0;
        clkr    <= ~clkr;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      div_cnt <= '0;
      clkr    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: SPI master/slave model, RX drain, end-to-end byte-order and timing reference.
module tb_spi_xfer_ctrl;
  localparam int DEPTH    = 4;
  localparam int CS_SETUP = 2;

  logic       clk, resetn;
  logic [7:0] clkdiv, tx_data, rx_data, spi_tx_byte, spi_rx_byte;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, cs_hold, busy, SPI_CS, clkr;
  logic       spi_transfer, spi_tx_busy, spi_rx_ready;

  int checks = 0, failures = 0;
  int cyc = 0, cs_falls = 0, cs_fall_cyc = 0, xfer_rise_cyc = 0, ck_period = 0, last_rise = 0;
  int falls, xcnt;
  logic prev_clkr, prev_cs = 1'b1, prev_xfer = 1'b0, prev_ck = 1'b0;
  logic resp_fixed_en = 1'b0, drain_en = 1'b0, drain_rand = 1'b0;
  logic [7:0] resp_fixed = 8'h00;
  logic [7:0] rx_got[$], tx_log[$], exp_q[$];
  int len_log[$];

  spi_xfer_ctrl #(.DEPTH(DEPTH), .CS_SETUP(CS_SETUP)) dut (
    .clk(clk), .resetn(resetn), .clkdiv(clkdiv), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cs_hold(cs_hold), .busy(busy), .SPI_CS(SPI_CS), .clkr(clkr), .spi_tx_byte(spi_tx_byte),
    .spi_transfer(spi_transfer), .spi_tx_busy(spi_tx_busy), .spi_rx_byte(spi_rx_byte),
    .spi_rx_ready(spi_rx_ready));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI master/slave model: a byte is done after 8 clkr periods; reply is an echo or a fixed byte.
  initial begin
    spi_rx_ready = 1'b0; spi_rx_byte = 8'h00; spi_tx_busy = 1'b0;
    falls = 0; xcnt = 0; prev_clkr = 1'b0;
    forever begin
      @(negedge clk);
      spi_tx_busy = spi_transfer;
      if (spi_rx_ready) begin
        spi_rx_ready = 1'b0;
        falls = 0;
        #1;
        xcnt = spi_transfer ? 1 : 0;
      end else if (spi_transfer) begin
        xcnt++;
        if (prev_clkr && !clkr) falls++;
        if (falls == 8) begin
          spi_rx_ready = 1'b1;
          spi_rx_byte  = resp_fixed_en ? resp_fixed : spi_tx_byte;
          tx_log.push_back(spi_tx_byte);
          len_log.push_back(xcnt);
        end
      end else begin
        falls = 0;
        xcnt  = 0;
      end
      prev_clkr = clkr;
    end
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      rx_ready = drain_en && (!drain_rand || ($urandom_range(0, 1) == 1));
      if (rx_ready && rx_valid) rx_got.push_back(rx_data);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !SPI_CS) begin cs_falls++; cs_fall_cyc = cyc; end
      if (!prev_xfer && spi_transfer) xfer_rise_cyc = cyc;
      if (!prev_ck && clkr) begin ck_period = cyc - last_rise; last_rise = cyc; end
      prev_cs = SPI_CS; prev_xfer = spi_transfer; prev_ck = clkr;
    end
  end

  task automatic clear_logs();
    rx_got.delete(); tx_log.delete(); len_log.delete(); exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    tx_data = b; tx_valid = 1'b1;
    while (!tx_ready && t < 5000) begin @(negedge clk); t++; end
    if (!tx_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout byte=%h tx_ready stuck low", b);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    int t = 0;
    while (tx_log.size() < n && t < 5000) begin @(negedge clk); t++; end
    ok = (tx_log.size() >= n);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    int t = 0;
    while (rx_got.size() < n && t < 5000) begin @(negedge clk); t++; end
    ok = (rx_got.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    @(negedge clk);
    while (busy && t < 5000) begin @(negedge clk); t++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (SPI_CS !== 1'b1)       begin failures++; $display("FAIL reset_cs got=%b exp=1", SPI_CS); end
    if (clkr !== 1'b0)         begin failures++; $display("FAIL reset_clkr got=%b exp=0", clkr); end
    if (spi_transfer !== 1'b0) begin failures++; $display("FAIL reset_transfer got=%b exp=0", spi_transfer); end
    if (spi_tx_byte !== 8'h00) begin failures++; $display("FAIL reset_txbyte got=%h exp=00", spi_tx_byte); end
    if (tx_ready !== 1'b1)     begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    if (rx_valid !== 1'b0)     begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    clkdiv = 8'd1; cs_hold = 1'b0; drain_en = 1'b0;
    resp_fixed_en = 1'b1; resp_fixed = 8'h3C;
    push_byte(8'hA5);
    wait_log(1, ok);
    if (ok) wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done got=timeout exp=idle"); end
    checks += 8;
    if (xfer_rise_cyc - cs_fall_cyc != CS_SETUP)
      begin failures++; $display("FAIL single_setup got=%0d exp=%0d", xfer_rise_cyc - cs_fall_cyc, CS_SETUP); end
    if (len_log.size() < 1 || len_log[0] != 16 * 2 + 1)
      begin failures++; $display("FAIL single_len got=%0d exp=33", len_log.size() ? len_log[0] : -1); end
    if (ck_period != 4)      begin failures++; $display("FAIL single_clkr_period got=%0d exp=4", ck_period); end
    if (tx_log.size() < 1 || tx_log[0] !== 8'hA5)
      begin failures++; $display("FAIL single_mosi got=%h exp=a5", tx_log.size() ? tx_log[0] : 8'hxx); end
    if (rx_data !== 8'h3C)   begin failures++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
    if (rx_valid !== 1'b1)   begin failures++; $display("FAIL single_rx_valid got=%b exp=1", rx_valid); end
    if (SPI_CS !== 1'b1)     begin failures++; $display("FAIL single_cs got=%b exp=1", SPI_CS); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    drain_en = 1'b1;
    wait_rx(1, ok);
    @(negedge clk);
    checks += 2;
    if (!ok || rx_got[0] !== 8'h3C) begin failures++; $display("FAIL single_pop got=%h exp=3c", ok ? rx_got[0] : 8'hxx); end
    if (rx_valid !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", rx_valid); end
    resp_fixed_en = 1'b0;
  endtask

  task automatic test_burst();
    bit ok;
    int f0;
    clear_logs();
    clkdiv = 8'd0; drain_en = 1'b1; drain_rand = 1'b0; f0 = cs_falls;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    wait_rx(4, ok);
    if (ok) wait_idle(ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL burst_done got=timeout exp=4 bytes"); end
    if (cs_falls - f0 != 1) begin failures++; $display("FAIL burst_cs_pulses got=%0d exp=1", cs_falls - f0); end
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (i >= rx_got.size() || rx_got[i] !== 8'(i + 1))
        begin failures++; $display("FAIL burst_rx[%0d] got=%h exp=%h", i, i < rx_got.size() ? rx_got[i] : 8'hxx, 8'(i + 1)); end
      if (i >= len_log.size() || len_log[i] != 17)
        begin failures++; $display("FAIL burst_len[%0d] got=%0d exp=17", i, i < len_log.size() ? len_log[i] : -1); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    clkdiv = 8'd0; cs_hold = 1'b0; drain_en = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
    wait_log(4, ok);
    repeat (100) @(negedge clk);
    checks += 3;
    if (tx_log.size() != 4) begin failures++; $display("FAIL bp_stalled got=%0d exp=4", tx_log.size()); end
    if (busy !== 1'b1)      begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
    if (rx_valid !== 1'b1)  begin failures++; $display("FAIL bp_rx_valid got=%b exp=1", rx_valid); end
    drain_en = 1'b1;
    wait_rx(6, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_resume got=%0d exp=6", rx_got.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= rx_got.size() || rx_got[i] !== exp_q[i])
        begin failures++; $display("FAIL bp_rx[%0d] got=%h exp=%h", i, i < rx_got.size() ? rx_got[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_cs_hold();
    bit ok;
    int f0;
    clear_logs();
    clkdiv = 8'd1; cs_hold = 1'b1; drain_en = 1'b1; drain_rand = 1'b0; f0 = cs_falls;
    push_byte(8'h11);
    wait_rx(1, ok);
    repeat (20) @(negedge clk);
    checks += 2;
    if (SPI_CS !== 1'b0) begin failures++; $display("FAIL hold_gap_cs got=%b exp=0", SPI_CS); end
    if (busy !== 1'b1)   begin failures++; $display("FAIL hold_gap_busy got=%b exp=1", busy); end
    push_byte(8'h22);
    wait_rx(2, ok);
    repeat (3) @(negedge clk);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL hold_second got=timeout exp=2 bytes"); end
    if (SPI_CS !== 1'b0) begin failures++; $display("FAIL hold_after_cs got=%b exp=0", SPI_CS); end
    cs_hold = 1'b0;
    @(posedge clk); @(negedge clk);
    checks += 3;
    if (SPI_CS !== 1'b1)    begin failures++; $display("FAIL hold_release_cs got=%b exp=1", SPI_CS); end
    if (cs_falls - f0 != 1) begin failures++; $display("FAIL hold_cs_pulses got=%0d exp=1", cs_falls - f0); end
    if (rx_got.size() < 2 || rx_got[0] !== 8'h11 || rx_got[1] !== 8'h22)
      begin failures++; $display("FAIL hold_rx_order got=%0d bytes exp=11,22", rx_got.size()); end
  endtask

  task automatic test_tx_full();
    bit ok;
    int blocked_accepts = 0;
    clear_logs();
    clkdiv = 8'd0; cs_hold = 1'b0; drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
    wait_log(4, ok);
    repeat (10) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_tx_ready got=%b exp=0", tx_ready); end
    @(negedge clk);
    tx_data = 8'hEE; tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_ready) blocked_accepts++;
    end
    tx_valid = 1'b0;
    checks++;
    if (blocked_accepts != 0) begin failures++; $display("FAIL full_blocked got=%0d accepts exp=0", blocked_accepts); end
    drain_en = 1'b1;
    push_byte(8'hEE);
    wait_rx(4 + DEPTH + 1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_drain got=%0d exp=%0d", rx_got.size(), 4 + DEPTH + 1); end
    for (int i = 0; i < 4 + DEPTH + 1; i++) begin
      checks++;
      if (i >= rx_got.size() || i >= exp_q.size() || rx_got[i] !== exp_q[i])
        begin failures++; $display("FAIL full_rx[%0d] got=%h exp=%h", i, i < rx_got.size() ? rx_got[i] : 8'hxx, i < exp_q.size() ? exp_q[i] : 8'hxx); end
    end
  endtask

  task automatic test_clkdiv_change();
    bit ok;
    clear_logs();
    clkdiv = 8'd2; cs_hold = 1'b0; drain_en = 1'b1; drain_rand = 1'b0;
    push_byte(8'h5A);
    repeat (6) @(negedge clk);
    clkdiv = 8'd7;
    wait_log(1, ok);
    if (ok) wait_idle(ok);
    push_byte(8'hC3);
    wait_rx(2, ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL div_done got=timeout exp=2 bytes"); end
    if (len_log.size() < 1 || len_log[0] != 49)
      begin failures++; $display("FAIL div_midchange_len got=%0d exp=49", len_log.size() ? len_log[0] : -1); end
    if (len_log.size() < 2 || len_log[1] != 129)
      begin failures++; $display("FAIL div_next_len got=%0d exp=129", len_log.size() > 1 ? len_log[1] : -1); end
  endtask

  task automatic test_random();
    bit ok;
    int d, k;
    for (int burst = 0; burst < 6; burst++) begin
      clear_logs();
      d = $urandom_range(0, 3);
      k = $urandom_range(1, 8);
      clkdiv = 8'(d); cs_hold = 1'($urandom_range(0, 1)); drain_en = 1'b1; drain_rand = 1'b1;
      for (int i = 0; i < k; i++) begin
        push_byte(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_rx(k, ok);
      cs_hold = 1'b0;
      if (ok) wait_idle(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rand%0d_done got=%0d exp=%0d", burst, rx_got.size(), k); end
      for (int i = 0; i < k; i++) begin
        checks += 2;
        if (i >= rx_got.size() || rx_got[i] !== exp_q[i])
          begin failures++; $display("FAIL rand%0d_rx[%0d] got=%h exp=%h", burst, i, i < rx_got.size() ? rx_got[i] : 8'hxx, exp_q[i]); end
        if (i >= len_log.size() || len_log[i] != 16 * (d + 1) + 1)
          begin failures++; $display("FAIL rand%0d_len[%0d] got=%0d exp=%0d", burst, i, i < len_log.size() ? len_log[i] : -1, 16 * (d + 1) + 1); end
      end
    end
    drain_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    clear_logs();
    clkdiv = 8'd1; cs_hold = 1'b0; drain_en = 1'b0;
    push_byte(8'h55);
    wait_log(1, ok);
    if (ok) wait_idle(ok);
    push_byte(8'h66);
    while (falls < 4 && t < 5000) begin @(negedge clk); t++; end
    checks++;
    if (falls < 4) begin failures++; $display("FAIL rstmid_reach got=%0d falls exp=4", falls); end
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    checks += 5;
    if (SPI_CS !== 1'b1)       begin failures++; $display("FAIL rstmid_cs got=%b exp=1", SPI_CS); end
    if (spi_transfer !== 1'b0) begin failures++; $display("FAIL rstmid_transfer got=%b exp=0", spi_transfer); end
    if (rx_valid !== 1'b0)     begin failures++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
    if (tx_ready !== 1'b1)     begin failures++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    checks += 2;
    if (tx_log.size() != 1) begin failures++; $display("FAIL rstmid_discard got=%0d bytes exp=1", tx_log.size()); end
    if (SPI_CS !== 1'b1)    begin failures++; $display("FAIL rstmid_stay_idle got=%b exp=1", SPI_CS); end
  endtask

  initial begin
    resetn = 1'b0; clkdiv = 8'd1; tx_data = 8'h00; tx_valid = 1'b0; cs_hold = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_cs_hold();
    test_tx_full();
    test_clkdiv_change();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
